// File: rtl/t09_score_tracker.sv
// Game score / session high score in 2-digit BCD plus the idle/play/over/win state machine.
// One-cycle latency from collision pulses to outputs; no backpressure, every pulse is acted on or ignored.
module t09_score_tracker #(
   parameter int MAX_SCORE = 50
) (
   input  logic       clk,
   input  logic       nRst,
   input  logic       start_i,
   input  logic       goodColl,
   input  logic       badColl,
   output logic [7:0] score_bcd,
   output logic [7:0] highScore_bcd,
   output logic [1:0] state_o,
   output logic       gameOver,
   output logic       win,
   output logic       newHigh,
   output logic       scoreInc
);

   localparam logic [3:0] MAX_TENS = 4'(MAX_SCORE / 10);
   localparam logic [3:0] MAX_ONES = 4'(MAX_SCORE % 10);
   localparam logic [7:0] MAX_BCD  = {MAX_TENS, MAX_ONES};

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      PLAY = 2'b01,
      OVER = 2'b10,
      WIN  = 2'b11
   } state_t;

   state_t     state;
   logic [7:0] inc_score;

   // Score is capped at MAX_SCORE (<= 99), so the tens digit never carries out.
   always_comb begin
      inc_score = score_bcd;
      if (score_bcd[3:0] == 4'd9) begin
         inc_score = {score_bcd[7:4] + 4'd1, 4'd0};
      end else begin
         inc_score = {score_bcd[7:4], score_bcd[3:0] + 4'd1};
      end
   end

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         state         <= IDLE;
         score_bcd     <= 8'h00;
         highScore_bcd <= 8'h00;
         newHigh       <= 1'b0;
         scoreInc      <= 1'b0;
      end else begin
         scoreInc <= 1'b0;
         case (state)
            PLAY: begin
               if (badColl) begin
                  state <= OVER;
               end else if (goodColl) begin
                  score_bcd <= inc_score;
                  scoreInc  <= 1'b1;
                  if (inc_score == MAX_BCD) begin
                     state <= WIN;
                  end
                  // Packed BCD compares correctly as plain binary.
                  if (inc_score > highScore_bcd) begin
                     highScore_bcd <= inc_score;
                     newHigh       <= 1'b1;
                  end
               end
            end
            default: begin
               if (start_i) begin
                  state     <= PLAY;
                  score_bcd <= 8'h00;
                  newHigh   <= 1'b0;
               end
            end
         endcase
      end
   end

   assign state_o  = state;
   assign gameOver = (state == OVER);
   assign win      = (state == WIN);

endmodule

// File: tb/tb_t09_score_tracker.sv
// Directed bench for t09_score_tracker with the default MAX_SCORE of 50.
module tb_t09_score_tracker;

   logic       clk;
   logic       nRst;
   logic       start_i;
   logic       goodColl;
   logic       badColl;
   logic [7:0] score_bcd;
   logic [7:0] highScore_bcd;
   logic [1:0] state_o;
   logic       gameOver;
   logic       win;
   logic       newHigh;
   logic       scoreInc;

   int checks = 0;
   int errors = 0;

   t09_score_tracker #(.MAX_SCORE(50)) dut (
      .clk           (clk),
      .nRst          (nRst),
      .start_i       (start_i),
      .goodColl      (goodColl),
      .badColl       (badColl),
      .score_bcd     (score_bcd),
      .highScore_bcd (highScore_bcd),
      .state_o       (state_o),
      .gameOver      (gameOver),
      .win           (win),
      .newHigh       (newHigh),
      .scoreInc      (scoreInc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] to_bcd(input int v);
      logic [7:0] r;
      r[7:4] = 4'(v / 10);
      r[3:0] = 4'(v % 10);
      return r;
   endfunction

   // Drive one cycle of inputs; returns #1 after the sampling edge with inputs back at 0.
   task automatic step(input logic g, input logic b, input logic s);
      @(negedge clk);
      goodColl = g;
      badColl  = b;
      start_i  = s;
      @(posedge clk);
      #1;
      goodColl = 1'b0;
      badColl  = 1'b0;
      start_i  = 1'b0;
   endtask

   task automatic test_reset();
      nRst = 1'b0; start_i = 1'b0; goodColl = 1'b0; badColl = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (state_o !== 2'b00) begin errors++; $display("FAIL reset_state got %b want 00", state_o); end
      checks++; if (score_bcd !== 8'h00) begin errors++; $display("FAIL reset_score got %h want 00", score_bcd); end
      checks++; if (highScore_bcd !== 8'h00) begin errors++; $display("FAIL reset_high got %h want 00", highScore_bcd); end
      checks++; if ({newHigh, scoreInc, gameOver, win} !== 4'b0000) begin errors++; $display("FAIL reset_flags got %b want 0000", {newHigh, scoreInc, gameOver, win}); end
      @(negedge clk);
      nRst = 1'b1;
   endtask

   task automatic test_idle_ignore();
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 1'b0, 1'b0);
         checks++; if (score_bcd !== 8'h00 || state_o !== 2'b00) begin errors++; $display("FAIL idle_good %0d got score %h state %b want 00/00", i, score_bcd, state_o); end
         checks++; if (scoreInc !== 1'b0) begin errors++; $display("FAIL idle_inc %0d got %b want 0", i, scoreInc); end
         step(1'b0, 1'b0, 1'b0);
      end
      step(1'b0, 1'b1, 1'b0);
      checks++; if (state_o !== 2'b00) begin errors++; $display("FAIL idle_bad got %b want 00", state_o); end
   endtask

   task automatic test_bcd_carry();
      int inc_seen = 0;
      step(1'b0, 1'b0, 1'b1);
      checks++; if (state_o !== 2'b01 || score_bcd !== 8'h00) begin errors++; $display("FAIL carry_start got state %b score %h want 01/00", state_o, score_bcd); end
      for (int i = 1; i <= 12; i++) begin
         step(1'b1, 1'b0, 1'b0);
         if (scoreInc === 1'b1) inc_seen++;
         checks++; if (score_bcd !== to_bcd(i)) begin errors++; $display("FAIL carry_score %0d got %h want %h", i, score_bcd, to_bcd(i)); end
         step(1'b0, 1'b0, 1'b0);
         checks++; if (scoreInc !== 1'b0) begin errors++; $display("FAIL carry_gap_inc %0d got %b want 0", i, scoreInc); end
      end
      checks++; if (inc_seen != 12) begin errors++; $display("FAIL carry_inc_count got %0d want 12", inc_seen); end
      checks++; if (highScore_bcd !== 8'h12 || newHigh !== 1'b1) begin errors++; $display("FAIL carry_high got %h/%b want 12/1", highScore_bcd, newHigh); end
      step(1'b0, 1'b1, 1'b0);
      checks++; if (state_o !== 2'b10 || gameOver !== 1'b1 || score_bcd !== 8'h12) begin errors++; $display("FAIL carry_over got %b/%b/%h want 10/1/12", state_o, gameOver, score_bcd); end
   endtask

   task automatic test_high_retention();
      step(1'b0, 1'b0, 1'b1);
      checks++; if (score_bcd !== 8'h00 || newHigh !== 1'b0 || highScore_bcd !== 8'h12 || state_o !== 2'b01) begin
         errors++; $display("FAIL ret_restart got %h/%b/%h/%b want 00/0/12/01", score_bcd, newHigh, highScore_bcd, state_o); end
      // start_i held alongside goodColl during play must not restart the game.
      for (int i = 1; i <= 12; i++) step(1'b1, 1'b0, (i == 6));
      checks++; if (score_bcd !== 8'h12 || newHigh !== 1'b0 || highScore_bcd !== 8'h12) begin
         errors++; $display("FAIL ret_tie got %h/%b/%h want 12/0/12", score_bcd, newHigh, highScore_bcd); end
      step(1'b1, 1'b0, 1'b0);
      checks++; if (score_bcd !== 8'h13 || newHigh !== 1'b1 || highScore_bcd !== 8'h13) begin
         errors++; $display("FAIL ret_beat got %h/%b/%h want 13/1/13", score_bcd, newHigh, highScore_bcd); end
      step(1'b0, 1'b1, 1'b0);
   endtask

   task automatic test_simultaneous();
      step(1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'b0);
      checks++; if (score_bcd !== 8'h07) begin errors++; $display("FAIL sim_pre got %h want 07", score_bcd); end
      step(1'b1, 1'b1, 1'b0);
      checks++; if (state_o !== 2'b10 || gameOver !== 1'b1 || score_bcd !== 8'h07 || scoreInc !== 1'b0) begin
         errors++; $display("FAIL sim_both got %b/%b/%h/%b want 10/1/07/0", state_o, gameOver, score_bcd, scoreInc); end
      step(1'b1, 1'b0, 1'b0);
      checks++; if (score_bcd !== 8'h07 || scoreInc !== 1'b0 || highScore_bcd !== 8'h13) begin
         errors++; $display("FAIL sim_over_hold got %h/%b/%h want 07/0/13", score_bcd, scoreInc, highScore_bcd); end
   endtask

   task automatic test_win_back_to_back();
      int inc_seen = 0;
      int bad_steps = 0;
      step(1'b0, 1'b0, 1'b1);
      for (int i = 1; i <= 50; i++) begin
         step(1'b1, 1'b0, 1'b0);
         if (scoreInc === 1'b1) inc_seen++;
         if (score_bcd !== to_bcd(i)) bad_steps++;
         if (i < 50 && state_o !== 2'b01) bad_steps++;
      end
      checks++; if (inc_seen != 50) begin errors++; $display("FAIL b2b_inc_count got %0d want 50", inc_seen); end
      checks++; if (bad_steps != 0) begin errors++; $display("FAIL b2b_score_steps got %0d bad want 0", bad_steps); end
      checks++; if (score_bcd !== 8'h50 || state_o !== 2'b11 || win !== 1'b1 || gameOver !== 1'b0) begin
         errors++; $display("FAIL win_reach got %h/%b/%b/%b want 50/11/1/0", score_bcd, state_o, win, gameOver); end
      checks++; if (highScore_bcd !== 8'h50 || newHigh !== 1'b1) begin errors++; $display("FAIL win_high got %h/%b want 50/1", highScore_bcd, newHigh); end
      step(1'b1, 1'b0, 1'b0);
      checks++; if (score_bcd !== 8'h50 || scoreInc !== 1'b0 || state_o !== 2'b11) begin
         errors++; $display("FAIL win_hold got %h/%b/%b want 50/0/11", score_bcd, scoreInc, state_o); end
   endtask

   task automatic test_async_reset();
      step(1'b0, 1'b0, 1'b1);
      checks++; if (score_bcd !== 8'h00 || highScore_bcd !== 8'h50 || state_o !== 2'b01) begin
         errors++; $display("FAIL arst_restart got %h/%h/%b want 00/50/01", score_bcd, highScore_bcd, state_o); end
      for (int i = 0; i < 25; i++) step(1'b1, 1'b0, 1'b0);
      checks++; if (score_bcd !== 8'h25 || state_o !== 2'b01) begin errors++; $display("FAIL arst_pre got %h/%b want 25/01", score_bcd, state_o); end
      @(negedge clk);
      #1 nRst = 1'b0;
      #1;
      checks++; if (score_bcd !== 8'h00 || highScore_bcd !== 8'h00 || state_o !== 2'b00) begin
         errors++; $display("FAIL arst_regs got %h/%h/%b want 00/00/00", score_bcd, highScore_bcd, state_o); end
      checks++; if ({newHigh, scoreInc, gameOver, win} !== 4'b0000) begin errors++; $display("FAIL arst_flags got %b want 0000", {newHigh, scoreInc, gameOver, win}); end
      @(negedge clk);
      nRst = 1'b1;
   endtask

   initial begin
      test_reset();
      test_idle_ignore();
      test_bcd_carry();
      test_high_retention();
      test_simultaneous();
      test_win_back_to_back();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
